async_pipe_rx: RTL and testbench

Clocked receiver at the output end of the asynchronous pipeline. It terminates the 4-phase bundled-data handshake (req/ack) from the last self-timed stage and synchronises req into the i_clk domain. Captured words go into a small show-ahead FIFO, which presents them downstream on a valid/ready interface. When the FIFO is full, the block applies backpressure by withholding ack, so no word is ever dropped.

---
 rtl/async_pipe_rx.sv | 167 ++++++++++++++++
 tb/tb_async_pipe_rx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/async_pipe_rx.sv
`default_nettype none
// ============================================================================
// Module      : async_pipe_rx
// Description : Clocked receiver for the output end of an asynchronous
//               pipeline. It terminates a 4-phase bundled-data req/ack
//               handshake, passes req through a two-flop synchroniser and
//               stores each captured word in a show-ahead FIFO. The FIFO
//               drives a valid/ready interface downstream. When the FIFO is
//               full, ack is withheld, so the sender stalls and no word is
//               lost.
// Ports       : i_clk    - system clock, rising-edge active
//               i_rst    - synchronous reset, active-high
//               i_req    - asynchronous 4-phase request (level based)
//               i_data   - bundled data, stable while req=1 and ack=0
//               o_ack    - registered acknowledge back to the pipeline
//               o_data   - FIFO head word (valid when o_valid=1)
//               o_valid  - FIFO non-empty
//               i_ready  - downstream accepts o_data this cycle
//               o_level  - FIFO occupancy, 0..DEPTH
//               o_rx_cnt - words accepted since reset, 16-bit wrapping
// Revision    : 1.0 - initial release
// ============================================================================
module async_pipe_rx #(
  parameter int DW    = 8,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req,
  input  logic [DW-1:0] i_data,
  output logic          o_ack,
  output logic [DW-1:0] o_data,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [AW:0]   o_level,
  output logic [15:0]   o_rx_cnt
);

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } state_t;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic          r_s1;
  logic          r_s2;
  state_t        r_state;
  logic          r_ack;
  logic [15:0]   r_rx_cnt;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_level;
  logic [DW-1:0] r_mem [DEPTH];

  // --------------------------------------------------------------------------
  // Combinational control
  // --------------------------------------------------------------------------
  logic w_req_s;
  logic w_full;
  logic w_valid;
  logic w_push;
  logic w_pop;

  assign w_req_s = r_s2;
  // Full is judged on the pre-edge level. A pop in the same cycle does not
  // make room for this cycle's push; the request is taken on a later edge.
  assign w_full  = (r_level == c_depth);
  assign w_valid = (r_level != '0);
  assign w_push  = (r_state == ST_IDLE) && w_req_s && !w_full;
  assign w_pop   = w_valid && i_ready;

  // --------------------------------------------------------------------------
  // Two-flop synchroniser. There is deliberately no logic between the flops.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= i_req;
      r_s2 <= r_s1;
    end
  end

  // --------------------------------------------------------------------------
  // Handshake FSM with registered ack, word counter and write pointer.
  // The write, the ack rise and the counter increment all take effect on the
  // same edge, so a word is acknowledged only once it is stored.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= ST_IDLE;
      r_ack    <= 1'b0;
      r_rx_cnt <= 16'd0;
      r_wr_ptr <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack <= 1'b0;
          if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
            r_rx_cnt <= r_rx_cnt + 16'd1;
            r_ack    <= 1'b1;
            r_state  <= ST_ACK;
          end
        end
        ST_ACK: begin
          r_ack <= 1'b1;
          // Wait for the sender to return req to zero before closing the
          // cycle. This completes the 4-phase return-to-zero.
          if (!w_req_s) begin
            r_ack   <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_ack   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FIFO storage. The contents need no reset: o_valid hides stale entries.
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // --------------------------------------------------------------------------
  // Read pointer and occupancy
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign o_ack    = r_ack;
  assign o_data   = r_mem[r_rd_ptr];
  assign o_valid  = w_valid;
  assign o_level  = r_level;
  assign o_rx_cnt = r_rx_cnt;

endmodule
`default_nettype wire

// File: tb/tb_async_pipe_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_async_pipe_rx
// Description : Directed self-checking bench for async_pipe_rx. It uses a
//               handshaking sender plus a pop monitor that checks each word
//               leaving the FIFO against an expected-order queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_async_pipe_rx;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst;
  logic          r_req;
  logic [DW-1:0] r_data;
  logic          w_ack;
  logic [DW-1:0] w_data;
  logic          w_valid;
  logic          r_ready;
  logic [AW:0]   w_level;
  logic [15:0]   w_rx_cnt;

  int n_checks;
  int n_errors;
  int n_pops;
  logic [DW-1:0] exp_q[$];

  async_pipe_rx #(.DW(DW), .DEPTH(DEPTH)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (r_req),
    .i_data  (r_data),
    .o_ack   (w_ack),
    .o_data  (w_data),
    .o_valid (w_valid),
    .i_ready (r_ready),
    .o_level (w_level),
    .o_rx_cnt(w_rx_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop monitor: a pop happens at the next rising edge when valid&ready are
  // high. Sampling on the falling edge sees stable values.
  always @(negedge clk) begin
    if (!rst && w_valid === 1'b1 && r_ready === 1'b1) begin
      n_pops++;
      if (exp_q.size() == 0) begin
        check_eq("pop_unexpected", 32'(w_data), 32'hFFFF_FFFF);
      end else begin
        check_eq("pop_data", 32'(w_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic wait_ack(input logic v);
    int n;
    n = 0;
    while (w_ack !== v && n < 20) begin
      tick();
      n++;
    end
    check_eq("ack_wait", 32'(w_ack), 32'(v));
  endtask

  task automatic send(input logic [DW-1:0] d);
    r_data = d;
    r_req  = 1'b1;
    exp_q.push_back(d);
    wait_ack(1'b1);
    r_req = 1'b0;
    wait_ack(1'b0);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    r_req   = 1'b0;
    r_ready = 1'b0;
    tick();
    tick();
    exp_q.delete();
    n_pops = 0;
    rst = 1'b0;
  endtask

  task automatic drain();
    r_ready = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    r_ready = 1'b0;
    check_eq("drain_level", 32'(w_level), 32'd0);
    check_eq("drain_q", exp_q.size(), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    n_pops   = 0;
    rst      = 1'b1;
    r_req    = 1'b1;
    r_data   = '0;
    r_ready  = 1'b0;

    // ---- Reset held with req high ----
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("rst_ack", 32'(w_ack), 32'd0);
      check_eq("rst_valid", 32'(w_valid), 32'd0);
      check_eq("rst_level", 32'(w_level), 32'd0);
      check_eq("rst_cnt", 32'(w_rx_cnt), 32'd0);
    end
    do_reset();

    // ---- Single word with exact latency ----
    r_data = 8'hA5;
    r_req  = 1'b1;
    exp_q.push_back(8'hA5);
    tick(); check_eq("single_ack_k", 32'(w_ack), 32'd0);
    tick(); check_eq("single_ack_k1", 32'(w_ack), 32'd0);
    tick(); check_eq("single_ack_k2", 32'(w_ack), 32'd1);
    check_eq("single_valid_k2", 32'(w_valid), 32'd1);
    r_req = 1'b0;
    tick(); check_eq("single_fall_m", 32'(w_ack), 32'd1);
    tick(); check_eq("single_fall_m1", 32'(w_ack), 32'd1);
    tick(); check_eq("single_fall_m2", 32'(w_ack), 32'd0);
    check_eq("single_valid", 32'(w_valid), 32'd1);
    check_eq("single_data", 32'(w_data), 32'hA5);
    check_eq("single_level", 32'(w_level), 32'd1);
    check_eq("single_cnt", 32'(w_rx_cnt), 32'd1);
    drain();
    check_eq("single_pops", n_pops, 32'd1);

    // ---- Stream with ready held high ----
    do_reset();
    r_ready = 1'b1;
    for (int i = 0; i < 9; i++) send(8'(i));
    for (int i = 0; i < 4; i++) tick();
    check_eq("stream_cnt", 32'(w_rx_cnt), 32'd9);
    check_eq("stream_pops", n_pops, 32'd9);
    check_eq("stream_level", 32'(w_level), 32'd0);
    r_ready = 1'b0;

    // ---- Backpressure when full ----
    do_reset();
    for (int i = 0; i < 4; i++) send(8'h10 + 8'(i));
    check_eq("bp_level4", 32'(w_level), 32'd4);
    r_data = 8'h14;
    r_req  = 1'b1;
    exp_q.push_back(8'h14);
    for (int i = 0; i < 6; i++) tick();
    check_eq("bp_ack_held", 32'(w_ack), 32'd0);
    check_eq("bp_cnt4", 32'(w_rx_cnt), 32'd4);
    r_ready = 1'b1;
    tick();
    r_ready = 1'b0;
    check_eq("bp_pop_level", 32'(w_level), 32'd3);
    check_eq("bp_pop_noack", 32'(w_ack), 32'd0);
    tick();
    check_eq("bp_late_ack", 32'(w_ack), 32'd1);
    check_eq("bp_relevel", 32'(w_level), 32'd4);
    check_eq("bp_cnt5", 32'(w_rx_cnt), 32'd5);
    r_req = 1'b0;
    wait_ack(1'b0);
    drain();
    check_eq("bp_pops", n_pops, 32'd5);

    // ---- Push and pop together at level 2, across pointer wrap ----
    do_reset();
    send(8'hC0);
    send(8'hC1);
    check_eq("wrap_level2", 32'(w_level), 32'd2);
    for (int i = 2; i < 10; i++) begin
      r_data = 8'hC0 + 8'(i);
      r_req  = 1'b1;
      exp_q.push_back(r_data);
      tick();
      tick();
      r_ready = 1'b1;
      tick();
      r_ready = 1'b0;
      check_eq("wrap_ack", 32'(w_ack), 32'd1);
      check_eq("wrap_level", 32'(w_level), 32'd2);
      r_req = 1'b0;
      wait_ack(1'b0);
    end
    check_eq("wrap_cnt", 32'(w_rx_cnt), 32'd10);
    drain();
    check_eq("wrap_pops", n_pops, 32'd10);

    // ---- Reset while ack is high with req held ----
    do_reset();
    r_data = 8'h77;
    r_req  = 1'b1;
    wait_ack(1'b1);
    rst = 1'b1;
    tick();
    tick();
    check_eq("mid_rst_ack", 32'(w_ack), 32'd0);
    check_eq("mid_rst_cnt", 32'(w_rx_cnt), 32'd0);
    exp_q.delete();
    n_pops = 0;
    exp_q.push_back(8'h77);
    rst = 1'b0;
    tick(); check_eq("mid_ack_k", 32'(w_ack), 32'd0);
    tick(); check_eq("mid_ack_k1", 32'(w_ack), 32'd0);
    tick(); check_eq("mid_ack_k2", 32'(w_ack), 32'd1);
    check_eq("mid_cnt", 32'(w_rx_cnt), 32'd1);
    r_req = 1'b0;
    wait_ack(1'b0);
    drain();
    check_eq("mid_pops", n_pops, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
